// File: rtl/online_adder_sd_multi.sv
// LANES-wide online adder/subtractor for radix-2 signed-digit streams, MSD first.
// Online delay 2; each NDIGITS-digit frame is flushed automatically and yields NDIGITS+1 digits.
module online_adder_sd_multi #(
  parameter int unsigned NDIGITS = 8,
  parameter int unsigned LANES   = 1
) (
  input  logic               clk,
  input  logic               asyn_reset,
  input  logic [2*LANES-1:0] x_in,
  input  logic               x_vld,
  output logic               x_rdy,
  input  logic [2*LANES-1:0] y_in,
  input  logic               y_vld,
  output logic               y_rdy,
  input  logic               sub,
  output logic [2*LANES-1:0] z_out,
  output logic               z_vld,
  input  logic               z_rdy,
  output logic               z_last
);

  localparam int unsigned CW = $clog2(NDIGITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIGITS - 1);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t               state;
  logic [CW-1:0]        count;
  logic                 flush_second;
  logic                 sub_q;
  logic [LANES-1:0][2:0] s_prev;  // s_{k-1}, two's complement
  logic [LANES-1:0][1:0] u_prev;  // u_{k-2}, two's complement

  logic                  out_free;
  logic                  first_step;
  logic                  step;
  logic                  emit;
  logic                  sub_eff;
  logic [1:0]            xv;
  logic [1:0]            yv;
  logic [1:0]            y_dig;
  logic                  nxt_nonneg;
  logic [LANES-1:0][2:0] s_new;
  logic [LANES-1:0][1:0] c_cur;
  logic [LANES-1:0][1:0] u_new;
  logic [2*LANES-1:0]    z_c;

  // Digit code to two's complement value; 11 reads as zero.
  function automatic logic [1:0] sd_value(input logic [1:0] d);
    case (d)
      2'b10:   return 2'b01;
      2'b01:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] sd_code(input logic [1:0] v);
    case (v)
      2'b01:   return 2'b10;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  always_comb begin
    out_free   = !z_vld || z_rdy;
    x_rdy      = (state == RUN) && !asyn_reset && out_free;
    y_rdy      = x_rdy;
    first_step = (state == RUN) && (count == '0);
    step       = (state == RUN) ? (x_vld && y_vld && x_rdy) : (out_free && !asyn_reset);
    emit       = step && !first_step;
    sub_eff    = first_step ? sub : sub_q;
    xv         = '0;
    yv         = '0;
    y_dig      = '0;
    nxt_nonneg = 1'b0;
    s_new      = '0;
    c_cur      = '0;
    u_new      = '0;
    z_c        = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      y_dig = sub_eff ? {y_in[2*i], y_in[2*i+1]} : y_in[2*i +: 2];
      xv    = sd_value(x_in[2*i +: 2]);
      yv    = sd_value(y_dig);
      if (state == RUN) s_new[i] = {xv[1], xv} + {yv[1], yv};
      nxt_nonneg = !s_new[i][2];
      // Split s_{k-1} = 2c + u, choosing u so that u + next carry stays in {-1,0,1}
      case (s_prev[i])
        3'b010: c_cur[i] = 2'b01;
        3'b110: c_cur[i] = 2'b11;
        3'b001: begin
          c_cur[i] = nxt_nonneg ? 2'b01 : 2'b00;
          u_new[i] = nxt_nonneg ? 2'b11 : 2'b01;
        end
        3'b111: begin
          c_cur[i] = nxt_nonneg ? 2'b00 : 2'b11;
          u_new[i] = nxt_nonneg ? 2'b11 : 2'b01;
        end
        default: begin
          c_cur[i] = 2'b00;
          u_new[i] = 2'b00;
        end
      endcase
      z_c[2*i +: 2] = sd_code(u_prev[i] + c_cur[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      state        <= RUN;
      count        <= '0;
      flush_second <= 1'b0;
      sub_q        <= 1'b0;
      s_prev       <= '0;
      u_prev       <= '0;
      z_out        <= '0;
      z_vld        <= 1'b0;
      z_last       <= 1'b0;
    end else begin
      if (step) begin
        s_prev <= s_new;
        u_prev <= u_new;
        if (first_step) sub_q <= sub;
        case (state)
          RUN: begin
            if (count == LAST_CNT) begin
              state <= FLUSH;
              count <= '0;
            end else begin
              count <= count + CW'(1);
            end
          end
          FLUSH: begin
            if (flush_second) begin
              state        <= RUN;
              flush_second <= 1'b0;
            end else begin
              flush_second <= 1'b1;
            end
          end
        endcase
      end
      if (emit) begin
        z_out  <= z_c;
        z_vld  <= 1'b1;
        z_last <= (state == FLUSH) && flush_second;
      end else if (z_rdy) begin
        z_vld  <= 1'b0;
        z_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_online_adder_sd_multi.sv
// Bench for online_adder_sd_multi: directed frames plus randomized frames against an arithmetic reference.
module tb_online_adder_sd_multi;

  localparam int N = 4;
  localparam int L = 2;
  localparam int W = 2 * L;

  typedef logic [W-1:0]   dig_t;
  typedef dig_t           frame_t [N];
  typedef logic [2*N-1:0] lane_t;

  logic         clk = 1'b0;
  logic         asyn_reset;
  logic [W-1:0] x_in, y_in, z_out;
  logic         x_vld, y_vld, x_rdy, y_rdy, sub, z_vld, z_rdy, z_last;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int low_cnt  = 0;
  bit low_en   = 1'b0;

  logic [W:0] zq [$];
  int         zcyc [$];
  int         hq [$];
  logic [W:0] expq [$];
  int         sumq [$];

  online_adder_sd_multi #(.NDIGITS(N), .LANES(L)) dut (
    .clk(clk), .asyn_reset(asyn_reset),
    .x_in(x_in), .x_vld(x_vld), .x_rdy(x_rdy),
    .y_in(y_in), .y_vld(y_vld), .y_rdy(y_rdy),
    .sub(sub),
    .z_out(z_out), .z_vld(z_vld), .z_rdy(z_rdy), .z_last(z_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Records handshakes on the falling edge, ahead of the rising edge that commits them.
  always @(negedge clk) begin
    if (!asyn_reset) begin
      if (x_vld && y_vld && x_rdy) hq.push_back(cyc);
      if (z_vld && z_rdy) begin
        zq.push_back({z_last, z_out});
        zcyc.push_back(cyc);
      end
      if (low_en && !x_rdy) low_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dval(input logic [1:0] d);
    return (d == 2'b10) ? 1 : (d == 2'b01) ? -1 : 0;
  endfunction

  function automatic logic [1:0] dcode(input int v);
    return (v > 0) ? 2'b10 : (v < 0) ? 2'b01 : 2'b00;
  endfunction

  // Reference: s_j per lane, carry/sum split with one-digit lookahead, z_j = u_j + c_{j+1}.
  function automatic void ref_frame(input frame_t xs, input frame_t ys, input bit s);
    int sv [N+3];
    int c  [N+3];
    int u  [N+3];
    logic [W:0] e [N+1];
    int xv, yv, acc;
    for (int j = 0; j <= N; j++) e[j] = '0;
    for (int l = 0; l < L; l++) begin
      acc = 0;
      for (int j = 0; j < N + 3; j++) begin
        sv[j] = 0; c[j] = 0; u[j] = 0;
      end
      for (int j = 1; j <= N; j++) begin
        xv    = dval(xs[j-1][2*l +: 2]);
        yv    = dval(ys[j-1][2*l +: 2]);
        sv[j] = s ? xv - yv : xv + yv;
        acc  += sv[j] * (1 << (N - j));
      end
      for (int j = 1; j <= N + 1; j++) begin
        case (sv[j])
          2:  c[j] = 1;
          -2: c[j] = -1;
          1:  if (sv[j+1] >= 0) begin c[j] = 1; u[j] = -1; end else u[j] = 1;
          -1: if (sv[j+1] >= 0) u[j] = -1; else begin c[j] = -1; u[j] = 1; end
          default: ;
        endcase
      end
      e[0][2*l +: 2] = dcode(c[1]);
      for (int j = 1; j <= N; j++) e[j][2*l +: 2] = dcode(u[j] + c[j+1]);
      sumq.push_back(acc);
    end
    e[N][W] = 1'b1;
    for (int j = 0; j <= N; j++) expq.push_back(e[j]);
  endfunction

  function automatic void build(input lane_t l0, input lane_t l1, output frame_t f);
    for (int k = 0; k < N; k++) f[k] = {l1[2*(N-1-k) +: 2], l0[2*(N-1-k) +: 2]};
  endfunction

  function automatic logic [2*(N+1)-1:0] lane_seq(input int lane);
    logic [2*(N+1)-1:0] r = '0;
    if (zq.size() >= N + 1)
      for (int j = 0; j <= N; j++) r[2*(N-j) +: 2] = zq[j][2*lane +: 2];
    return r;
  endfunction

  // Drives ndig digits; sub is only meaningful on the first, so later digits carry noise.
  task automatic send_frame(input frame_t xs, input frame_t ys, input bit s, input int ndig,
                            input bit rnd_vld, input bit rnd_rdy);
    bit done;
    int guard;
    if (ndig == N) ref_frame(xs, ys, s);
    for (int k = 0; k < ndig; k++) begin
      done  = 1'b0;
      guard = 0;
      while (!done && guard <= 200) begin
        x_in  = xs[k];
        y_in  = ys[k];
        sub   = (k == 0) ? s : 1'($urandom);
        x_vld = rnd_vld ? 1'($urandom) : 1'b1;
        y_vld = rnd_vld ? 1'($urandom) : 1'b1;
        if (rnd_rdy) z_rdy = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        done = x_vld && y_vld && x_rdy;
        @(posedge clk); #1;
        guard++;
      end
      if (!done) chk($sformatf("handshake timeout digit %0d", k), 32'(done), 32'(1));
    end
    x_vld = 1'b0;
    y_vld = 1'b0;
    if (rnd_rdy) z_rdy = 1'b1;
  endtask

  task automatic wait_out(input int n);
    int g = 0;
    while (zq.size() < n && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
  endtask

  task automatic check_out(input string tag);
    int nexp, nf, acc;
    nexp = expq.size();
    wait_out(nexp);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, " digit count"}, 32'(zq.size()), 32'(nexp));
    for (int i = 0; i < nexp && i < zq.size(); i++)
      chk($sformatf("%s digit %0d", tag, i), 32'(zq[i]), 32'(expq[i]));
    nf = nexp / (N + 1);
    for (int f = 0; f < nf; f++)
      for (int l = 0; l < L; l++)
        if ((f + 1) * (N + 1) <= zq.size()) begin
          acc = 0;
          for (int j = 0; j <= N; j++) acc += dval(zq[f*(N+1)+j][2*l +: 2]) * (1 << (N - j));
          chk($sformatf("%s value f%0d lane%0d", tag, f, l), 32'(acc), 32'(sumq[f*L+l]));
        end
    zq.delete(); zcyc.delete(); hq.delete(); expq.delete(); sumq.delete();
  endtask

  initial begin
    frame_t fx, fy;
    lane_t  ax, ay, ax11, ay11, cx, rx0, ry0, rx1, ry1;
    logic [W+1:0] snap;
    int g;

    ax   = 8'b10_00_10_00;
    ay   = 8'b00_10_10_00;
    ax11 = 8'b10_11_10_11;
    ay11 = 8'b11_10_10_11;
    cx   = 8'b01_01_01_01;

    asyn_reset = 1'b1;
    x_in = '0; y_in = '0; x_vld = 1'b0; y_vld = 1'b0; sub = 1'b0; z_rdy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ready in reset", 32'({x_rdy, y_rdy}), 32'(0));
    end
    chk("z_vld in reset", 32'(z_vld), 32'(0));
    @(posedge clk); #1;
    asyn_reset = 1'b0;
    @(negedge clk);
    chk("ready after reset", 32'({x_rdy, y_rdy}), 32'(3));
    chk("outputs after reset", 32'({z_vld, z_last, z_out}), 32'(0));

    // Add; lane1 uses 11 where lane0 has 00.
    build(ax, ax11, fx); build(ay, ay11, fy);
    @(posedge clk); #1;
    hq.delete();
    send_frame(fx, fy, 1'b0, N, 1'b0, 1'b0);
    wait_out(N + 1);
    chk("first z latency", 32'(zcyc[0] - hq[0]), 32'(2));
    chk("add lane0 seq", 32'(lane_seq(0)), 32'(10'b10_00_00_00_00));
    chk("add lane1 11-as-0 seq", 32'(lane_seq(1)), 32'(10'b10_00_00_00_00));
    check_out("add");

    build(ax, ax, fx); build(ay, ay, fy);
    send_frame(fx, fy, 1'b1, N, 1'b0, 1'b0);
    wait_out(N + 1);
    chk("sub lane0 seq", 32'(lane_seq(0)), 32'(10'b00_10_01_00_00));
    check_out("sub");

    build(cx, ax, fx); build(cx, ay, fy);
    send_frame(fx, fy, 1'b0, N, 1'b0, 1'b0);
    wait_out(N + 1);
    chk("neg lane0 seq", 32'(lane_seq(0)), 32'(10'b01_01_01_01_00));
    chk("neg lane1 seq", 32'(lane_seq(1)), 32'(10'b10_00_00_00_00));
    check_out("neg");

    // Backpressure: stall three cycles while z2 is presented.
    build(ax, cx, fx); build(ay, cx, fy);
    fork
      send_frame(fx, fy, 1'b0, N, 1'b0, 1'b0);
      begin
        g = 0;
        while (!(zq.size() == 2 && z_vld) && g < 100) begin
          @(posedge clk); #1;
          g++;
        end
        chk("bp reached z2", 32'(zq.size()), 32'(2));
        z_rdy = 1'b0;
        snap  = {z_vld, z_last, z_out};
        chk("bp stalled digit", 32'(snap[W:0]), 32'(expq[2]));
        repeat (3) begin
          @(negedge clk);
          chk("bp outputs stable", 32'({z_vld, z_last, z_out}), 32'(snap));
          chk("bp x_rdy low", 32'({x_rdy, y_rdy}), 32'(0));
        end
        @(posedge clk); #1;
        z_rdy = 1'b1;
      end
    join
    check_out("backpressure");

    // Abandon a frame after two digits, then run a clean frame.
    z_rdy = 1'b0;
    build(cx, cx, fx); build(cx, cx, fy);
    send_frame(fx, fy, 1'b1, 2, 1'b0, 1'b0);
    asyn_reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("mid reset ready", 32'({x_rdy, y_rdy}), 32'(0));
    end
    chk("mid reset z_vld", 32'({z_vld, z_last}), 32'(0));
    @(posedge clk); #1;
    asyn_reset = 1'b0;
    z_rdy = 1'b1;
    zq.delete(); zcyc.delete(); hq.delete();
    @(negedge clk);
    chk("post reset z_vld", 32'(z_vld), 32'(0));
    chk("post reset ready", 32'(x_rdy), 32'(1));
    @(posedge clk); #1;
    build(ax, ax, fx); build(ay, ay, fy);
    send_frame(fx, fy, 1'b0, N, 1'b0, 1'b0);
    wait_out(N + 1);
    chk("post reset lane0 seq", 32'(lane_seq(0)), 32'(10'b10_00_00_00_00));
    check_out("post reset");

    // Back-to-back frames with toggling valids; x_rdy drops only for the flush steps.
    low_cnt = 0;
    low_en  = 1'b1;
    build(ax, cx, fx); build(ay, cx, fy);
    send_frame(fx, fy, 1'b0, N, 1'b1, 1'b0);
    for (int f = 0; f < 5; f++) begin
      rx0 = lane_t'($urandom); ry0 = lane_t'($urandom);
      rx1 = lane_t'($urandom); ry1 = lane_t'($urandom);
      build(rx0, rx1, fx); build(ry0, ry1, fy);
      send_frame(fx, fy, 1'($urandom), N, 1'b1, 1'b0);
    end
    check_out("b2b");
    low_en = 1'b0;
    chk("b2b flush stall cycles", 32'(low_cnt), 32'(12));

    // Random frames with random consumer backpressure.
    for (int f = 0; f < 8; f++) begin
      rx0 = lane_t'($urandom); ry0 = lane_t'($urandom);
      rx1 = lane_t'($urandom); ry1 = lane_t'($urandom);
      build(rx0, rx1, fx); build(ry0, ry1, fy);
      send_frame(fx, fy, 1'($urandom), N, 1'b1, 1'b1);
    end
    check_out("random bp");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
